// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock.
// start/done handshake; L_T/G_T/E carry the same meaning as the combinational comparator.
module serial_magnitude_comparator #(
    parameter int N          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         L_T,
    output logic         G_T,
    output logic         E
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    typedef struct packed {
        logic l_t;
        logic g_t;
        logic e;
    } flags_t;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            dec_q, dec_d;
    logic            dir_q, dir_d;
    flags_t          flags_q, flags_d;

    logic            a_bit;
    logic            b_bit;
    logic            last_bit;

    assign a_bit    = a_q[idx_q];
    assign b_bit    = b_q[idx_q];
    assign last_bit = (idx_q == '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        dir_d   = dir_q;
        flags_d = flags_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COMPARE;
                    a_d     = A;
                    b_d     = B;
                    idx_d   = IW'(N - 1);
                    dec_d   = 1'b0;
                    dir_d   = 1'b0;
                    flags_d = '0;
                end
            end

            S_COMPARE: begin
                if (EARLY_EXIT) begin
                    if (a_bit != b_bit) begin
                        flags_d.g_t = a_bit;
                        flags_d.l_t = b_bit;
                        state_d     = S_DONE;
                    end else if (last_bit) begin
                        flags_d.e = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end else begin
                    // Only the most significant difference matters; later bits are ignored.
                    if (!dec_q && (a_bit != b_bit)) begin
                        dec_d = 1'b1;
                        dir_d = a_bit;
                    end
                    if (last_bit) begin
                        state_d = S_DONE;
                        if (dec_d) begin
                            flags_d.g_t = dir_d;
                            flags_d.l_t = ~dir_d;
                        end else begin
                            flags_d.e = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            dir_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            dir_q   <= dir_d;
            flags_q <= flags_d;
        end
    end

    // Handshake outputs decode straight from the state so reset clears them without an edge.
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign L_T  = flags_q.l_t;
    assign G_T  = flags_q.g_t;
    assign E    = flags_q.e;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: one early-exit and one constant-latency
// instance, expected results queued at stimulus time and checked when done pulses.
module tb_serial_magnitude_comparator;

    localparam int N = 10;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start1 = 1'b0, start0 = 1'b0;
    logic [N-1:0] a1 = '0, b1 = '0, a0 = '0, b0 = '0;
    logic         busy1, done1, lt1, gt1, e1;
    logic         busy0, done0, lt0, gt0, e0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.N(N), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .L_T(lt1), .G_T(gt1), .E(e1)
    );

    serial_magnitude_comparator #(.N(N), .EARLY_EXIT(1'b0)) u_cl (
        .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0),
        .busy(busy0), .done(done0), .L_T(lt0), .G_T(gt0), .E(e0)
    );

    typedef struct {
        logic lt;
        logic gt;
        logic e;
        int   m;
    } exp_t;

    exp_t sbq[$];
    int   nchk  = 0;
    int   npass = 0;

    function automatic exp_t model(logic [N-1:0] a, logic [N-1:0] b, bit ee);
        exp_t r;
        r.lt = (a < b);
        r.gt = (a > b);
        r.e  = (a == b);
        r.m  = N;
        if (ee)
            for (int i = 0; i < N; i++)
                if (a[i] != b[i]) r.m = N - i;
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic get_busy(bit sel);
        return sel ? busy1 : busy0;
    endfunction

    function automatic logic get_done(bit sel);
        return sel ? done1 : done0;
    endfunction

    function automatic logic [2:0] get_flags(bit sel);
        return sel ? {lt1, gt1, e1} : {lt0, gt0, e0};
    endfunction

    task automatic drive(bit sel, logic s, logic [N-1:0] a, logic [N-1:0] b);
        if (sel) begin
            start1 = s; a1 = a; b1 = b;
        end else begin
            start0 = s; a0 = a; b0 = b;
        end
    endtask

    // Called on the negedge right after the accept edge; counts edges until done.
    task automatic wait_done(bit sel, string tag);
        int   k    = 0;
        bit   seen = 1'b0;
        exp_t x;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (get_done(sel)) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 32'(0), 32'(1));
            if (sbq.size() > 0) x = sbq.pop_front();
            return;
        end
        x = sbq.pop_front();
        chk({tag, "_latency"}, 32'(k), 32'(x.m));
        chk({tag, "_flags"}, 32'(get_flags(sel)), 32'({x.lt, x.gt, x.e}));
        @(negedge clk);
        chk({tag, "_done_fall"}, 32'(get_done(sel)), 32'(0));
        chk({tag, "_busy_fall"}, 32'(get_busy(sel)), 32'(0));
    endtask

    // Entered on a negedge with the DUT idle; scrambles A/B while busy.
    task automatic do_cmp(bit sel, logic [N-1:0] a, logic [N-1:0] b, string tag);
        drive(sel, 1'b1, a, b);
        sbq.push_back(model(a, b, sel));
        @(negedge clk);
        drive(sel, 1'b0, ~a, b ^ 10'h155);
        chk({tag, "_busy"}, 32'(get_busy(sel)), 32'(1));
        chk({tag, "_clr"}, 32'(get_flags(sel)), 32'(0));
        wait_done(sel, tag);
    endtask

    initial begin
        logic [N-1:0] pa, pb;
        logic         cb, cd;
        bit           pbusy, pdone;
        int           k;
        exp_t         x;

        #12;
        chk("rst_outs_ee", 32'({busy1, done1, lt1, gt1, e1}), 32'(0));
        chk("rst_outs_cl", 32'({busy0, done0, lt0, gt0, e0}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Early-exit instance: LSB difference, mid difference, equal, MSB difference
        do_cmp(1'b1, 10'd60, 10'd61, "lsb_lt");
        do_cmp(1'b1, 10'd51, 10'd47, "bit4_gt");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("gt_hold", 32'(get_flags(1'b1)), 32'(3'b010));
        end
        do_cmp(1'b1, 10'd42, 10'd42, "eq");
        do_cmp(1'b1, 10'd1023, 10'd0, "msb_gt");

        // Constant-latency instance, including a later opposite difference
        do_cmp(1'b0, 10'd1023, 10'd0, "cl_gt");
        do_cmp(1'b0, 10'd0, 10'd512, "cl_lt");
        do_cmp(1'b0, 10'h200, 10'h1FF, "cl_sticky");
        do_cmp(1'b0, 10'd5, 10'd5, "cl_eq");

        // Start held high with operands changing every cycle
        pbusy = 1'b0;
        pdone = 1'b0;
        k     = 0;
        pa    = N'($urandom);
        pb    = N'($urandom);
        drive(1'b1, 1'b1, pa, pb);
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            cb = get_busy(1'b1);
            cd = get_done(1'b1);
            if (pdone) chk("held_idle_after_done", 32'(cb), 32'(0));
            if (cb && !pbusy) begin
                sbq.push_back(model(pa, pb, 1'b1));
                k = 0;
                chk("held_clr", 32'(get_flags(1'b1)), 32'(0));
            end else begin
                k++;
            end
            if (cd) begin
                if (sbq.size() == 0) begin
                    chk("held_spurious_done", 32'(1), 32'(0));
                end else begin
                    x = sbq.pop_front();
                    chk("held_latency", 32'(k), 32'(x.m));
                    chk("held_flags", 32'(get_flags(1'b1)), 32'({x.lt, x.gt, x.e}));
                end
            end
            pbusy = cb;
            pdone = cd;
            pa    = N'($urandom);
            pb    = N'($urandom);
            drive(1'b1, (c < 60), pa, pb);
        end
        chk("held_drain", 32'(sbq.size()), 32'(0));

        // Asynchronous reset in the third COMPARE cycle of 5 vs 6
        drive(1'b1, 1'b1, 10'd5, 10'd6);
        @(negedge clk);
        drive(1'b1, 1'b0, 10'd5, 10'd6);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy1), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy1), 32'(0));
        chk("rst_done", 32'(done1), 32'(0));
        chk("rst_flags", 32'(get_flags(1'b1)), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({busy1, done1, lt1, gt1, e1}), 32'(0));
        end
        do_cmp(1'b1, 10'd7, 10'd7, "post_rst_eq");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
